// File: rtl/flash_cmd_sequencer.sv
// JEDEC command sequencer for a 29F0x0 parallel flash: issues unlock/command write
// cycles in clocks the CPU leaves free, then polls DQ7/DQ5 for completion.
module flash_cmd_sequencer #(
    parameter int ADDR_WIDTH    = 19,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_reg,
    input  logic                  cmd_we,
    input  logic [1:0]            cmd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_data,
    input  logic                  cpu_busy,
    input  logic [7:0]            mem_rdata,
    output logic                  own_bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_wdata_oe,
    output logic                  flash_ce_n,
    output logic                  flash_we_n,
    output logic                  flash_oe_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_STROBE, POLL_RD, POLL_EVAL, ST_DONE, ST_ERR
    } state_t;

    localparam logic [1:0] OP_PROG   = 2'd0;
    localparam logic [1:0] OP_CERASE = 2'd2;
    localparam logic [1:0] OP_RESET  = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] A555 = ADDR_WIDTH'(12'h555);
    localparam logic [ADDR_WIDTH-1:0] A2AA = ADDR_WIDTH'(12'h2AA);

    state_t                   state, next_state;
    logic [1:0]               op;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [7:0]               data_q;
    logic [2:0]               step;
    logic [TIMEOUT_WIDTH-1:0] tmo;
    logic                     reread;
    logic                     rd_dq7, rd_dq5;
    logic [ADDR_WIDTH-1:0]    scr_addr;
    logic [7:0]               scr_data;
    logic                     last_step;
    logic                     accept, abort, dq7_ok, bus_state, wr_state;
    logic                     unused_rdata;

    assign unused_rdata = ^{mem_rdata[6], mem_rdata[4:0]};
    assign accept = cmd_we && !busy;
    assign abort  = cmd_we && busy && (cmd == OP_RESET);
    // Erase completion reads DQ7=1; program completion reads back the data bit
    assign dq7_ok = (rd_dq7 == ((op == OP_PROG) ? data_q[7] : 1'b1));

    // Write script: address/data of the current step
    always_comb begin
        scr_addr  = '0;
        scr_data  = 8'h00;
        last_step = 1'b0;
        if (op == OP_RESET) begin
            scr_data  = 8'hF0;
            last_step = 1'b1;
        end else if (op == OP_PROG) begin
            case (step)
                3'd0:    begin scr_addr = A555; scr_data = 8'hAA; end
                3'd1:    begin scr_addr = A2AA; scr_data = 8'h55; end
                3'd2:    begin scr_addr = A555; scr_data = 8'hA0; end
                default: begin scr_addr = addr_q; scr_data = data_q; last_step = 1'b1; end
            endcase
        end else begin
            case (step)
                3'd0, 3'd3: begin scr_addr = A555; scr_data = 8'hAA; end
                3'd1, 3'd4: begin scr_addr = A2AA; scr_data = 8'h55; end
                3'd2:       begin scr_addr = A555; scr_data = 8'h80; end
                default: begin
                    scr_addr  = (op == OP_CERASE) ? A555 : addr_q;
                    scr_data  = (op == OP_CERASE) ? 8'h10 : 8'h30;
                    last_step = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset_reg) begin
        if (reset_reg) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ST_DONE, ST_ERR:
                if (accept)             next_state = WR_SETUP;
                else                    next_state = IDLE;
            WR_SETUP:
                if (!cpu_busy)          next_state = WR_STROBE;
            WR_STROBE:
                if (cpu_busy)           next_state = WR_SETUP;
                else if (!last_step)    next_state = WR_SETUP;
                else if (op == OP_RESET) next_state = ST_DONE;
                else                    next_state = POLL_RD;
            POLL_RD:
                if (!cpu_busy)          next_state = POLL_EVAL;
            POLL_EVAL:
                if (dq7_ok)             next_state = ST_DONE;
                else if (reread)        next_state = ST_ERR;
                else if (rd_dq5)        next_state = POLL_RD;
                else if (tmo == '0)     next_state = ST_ERR;
                else                    next_state = POLL_RD;
            default:                    next_state = IDLE;
        endcase
        // A strobe in progress still completes this clock; the reset script follows
        if (abort) next_state = WR_SETUP;
    end

    always_ff @(posedge clock or posedge reset_reg) begin
        if (reset_reg) begin
            op     <= OP_PROG;
            addr_q <= '0;
            data_q <= 8'h00;
            step   <= 3'd0;
            tmo    <= '1;
            reread <= 1'b0;
            rd_dq7 <= 1'b0;
            rd_dq5 <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else if (accept) begin
            op     <= cmd;
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            step   <= 3'd0;
            tmo    <= '1;
            reread <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
        end else if (abort) begin
            op   <= OP_RESET;
            step <= 3'd0;
        end else begin
            if (state == WR_STROBE && !cpu_busy && !last_step)
                step <= step + 3'd1;
            if (state == POLL_RD && !cpu_busy) begin
                rd_dq7 <= mem_rdata[7];
                rd_dq5 <= mem_rdata[5];
            end
            if (state == POLL_EVAL && !dq7_ok && !reread) begin
                if (rd_dq5)          reread <= 1'b1;
                else if (tmo != '0)  tmo <= tmo - TIMEOUT_WIDTH'(1);
            end
            if (next_state == ST_DONE) begin done  <= 1'b1; busy <= 1'b0; end
            if (next_state == ST_ERR)  begin error <= 1'b1; busy <= 1'b0; end
        end
    end

    // Strobes are purely combinational so cpu_busy and reset_reg release the bus at once
    always_comb begin
        wr_state     = (state == WR_SETUP) || (state == WR_STROBE);
        bus_state    = wr_state || (state == POLL_RD);
        own_bus      = bus_state && !cpu_busy;
        flash_ce_n   = !own_bus;
        flash_we_n   = !(own_bus && state == WR_STROBE);
        flash_oe_n   = !(own_bus && state == POLL_RD);
        mem_wdata_oe = own_bus && wr_state;
        mem_addr     = '0;
        mem_wdata    = 8'h00;
        if (wr_state) begin
            mem_addr  = scr_addr;
            mem_wdata = scr_data;
        end else if (state == POLL_RD) begin
            mem_addr = (op == OP_CERASE) ? '0 : addr_q;
        end
    end
endmodule
